// File: rtl/arm_lsu_pkg.sv
// ============================================================================
// Module      : arm_lsu_pkg
// Description : Shared encodings for the ARMv4T load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_lsu_pkg;

    localparam logic [1:0] LSU_LOAD  = 2'd0;
    localparam logic [1:0] LSU_STORE = 2'd1;
    localparam logic [1:0] LSU_LDM   = 2'd2;
    localparam logic [1:0] LSU_STM   = 2'd3;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/arm_lsu_align.sv
// ============================================================================
// Module      : arm_lsu_align
// Description : Load lane select / rotate / extend and store lane replication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_lsu_align
    import arm_lsu_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic        sign_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_rot;

    always_comb begin
        case (lane_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase

        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Misaligned word loads rotate the aligned word right by the byte offset.
        case (lane_i)
            2'd1:    word_rot = {rdata_i[7:0],  rdata_i[31:8]};
            2'd2:    word_rot = {rdata_i[15:0], rdata_i[31:16]};
            2'd3:    word_rot = {rdata_i[23:0], rdata_i[31:24]};
            default: word_rot = rdata_i;
        endcase

        case (width_i)
            W_BYTE:  ld_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            W_HALF:  ld_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: ld_data_o = word_rot;
        endcase

        case (width_i)
            W_BYTE:  st_data_o = {4{wdata_i[7:0]}};
            W_HALF:  st_data_o = {2{wdata_i[15:0]}};
            default: st_data_o = wdata_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/arm_lsu.sv
// ============================================================================
// Module      : arm_lsu
// Description : ARMv4T load/store unit - single and LDM/STM bus sequencing.
//               Optional mem_ok timeout enabled by macro ARM_LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_lsu
    import arm_lsu_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int NREGS   = 16,
    parameter  int TMO_CYC = 255,
    localparam int IDX_W   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_width,
    input  logic              req_signed,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic [31:0]       req_wdata,
    input  logic [NREGS-1:0]  req_rlist,
    output logic [IDX_W-1:0]  rf_idx,
    input  logic [31:0]       rf_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_width,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ok,
    output logic              wb_en,
    output logic [IDX_W-1:0]  wb_idx,
    output logic [31:0]       wb_data,
    output logic              done,
    output logic              abort
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q;
    logic [1:0]        width_q;
    logic              sign_q;
    logic [IDX_W-1:0]  rd_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NREGS-1:0]  rlist_q;
    logic              wb_en_q;
    logic [IDX_W-1:0]  wb_idx_q;
    logic [31:0]       wb_data_q;

    logic [IDX_W-1:0]  cur_idx;
    logic [NREGS-1:0]  rlist_rest;
    logic              is_multi, is_store, list_empty, active, beat_ok, tmo_hit;
    logic [1:0]        al_width, al_lane;
    logic [31:0]       ld_data, st_data;

    always_comb begin
        cur_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (rlist_q[i]) cur_idx = IDX_W'(i);
        end
    end

    assign rlist_rest = rlist_q & (rlist_q - NREGS'(1));
    assign is_multi   = (op_q == LSU_LDM) || (op_q == LSU_STM);
    assign is_store   = (op_q == LSU_STORE) || (op_q == LSU_STM);
    assign list_empty = (rlist_q == '0);
    // An empty register list passes through ACCESS without strobes, keeping done at +2.
    assign active     = (state_q == S_ACCESS) && !(is_multi && list_empty);
    assign beat_ok    = active && mem_ok;

`ifdef ARM_LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] wait_q;

    always_ff @(posedge clk) begin
        if (!rstn || state_q != S_ACCESS || beat_ok) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + TMO_W'(1);
        end
    end

    assign tmo_hit = active && !mem_ok && (wait_q == TMO_W'(TMO_CYC - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TMO_CYC);
    assign tmo_hit    = 1'b0;
`endif

    assign al_width = is_multi ? W_WORD : width_q;
    assign al_lane  = is_multi ? 2'b00 : addr_q[1:0];

    arm_lsu_align u_align (
        .width_i   (al_width),
        .sign_i    (sign_q),
        .lane_i    (al_lane),
        .rdata_i   (mem_rdata),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .st_data_o (st_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (beat_ok) begin
                    state_d = (is_multi && rlist_rest != '0) ? S_ACCESS : S_DONE;
                end else if (is_multi && list_empty) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_width = '0;
        if (active) begin
            if (is_multi) begin
                mem_addr  = addr_q;
                mem_width = W_WORD;
                mem_wdata = rf_data;
            end else begin
                mem_width = width_q;
                mem_wdata = st_data;
                case (width_q)
                    W_BYTE:  mem_addr = addr_q;
                    W_HALF:  mem_addr = {addr_q[ADDR_W-1:1], 1'b0};
                    default: mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                endcase
            end
            if (!is_store) mem_wdata = '0;
        end
    end

    assign mem_read  = active && !is_store;
    assign mem_write = active && is_store;
    assign rf_idx    = cur_idx;
    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE) || tmo_hit;
    assign abort     = tmo_hit;
    assign wb_en     = wb_en_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            width_q   <= '0;
            sign_q    <= 1'b0;
            rd_q      <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            rlist_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            wb_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        width_q <= req_width;
                        sign_q  <= req_signed;
                        rd_q    <= req_rd;
                        wdata_q <= req_wdata;
                        if (req_op == LSU_LDM || req_op == LSU_STM) begin
                            addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            rlist_q <= req_rlist;
                        end else begin
                            addr_q  <= req_addr;
                            rlist_q <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (beat_ok) begin
                        if (!is_store) begin
                            wb_en_q   <= 1'b1;
                            wb_idx_q  <= is_multi ? cur_idx : rd_q;
                            wb_data_q <= ld_data;
                        end
                        if (is_multi) begin
                            rlist_q <= rlist_rest;
                            addr_q  <= addr_q + ADDR_W'(4);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arm_lsu.sv
// ============================================================================
// Module      : tb_arm_lsu
// Description : Directed self-checking bench for arm_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [3:0]  req_rd;
    logic [31:0] req_wdata;
    logic [15:0] req_rlist;
    logic [3:0]  rf_idx;
    logic [31:0] rf_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ok;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [31:0] wb_data;
    logic        done;
    logic        abort;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rf_data = 32'hCAFE_0000 | {28'h0, rf_idx};

    arm_lsu #(.ADDR_W(32), .NREGS(16), .TMO_CYC(4)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_width(req_width), .req_signed(req_signed),
        .req_rd(req_rd), .req_wdata(req_wdata), .req_rlist(req_rlist),
        .rf_idx(rf_idx), .rf_data(rf_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_ok(mem_ok), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .done(done), .abort(abort)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in the first ACCESS cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [1:0] w,
                         input logic sg, input logic [3:0] rd, input logic [31:0] wd,
                         input logic [15:0] rl);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_width = w;
        req_signed = sg; req_rd = rd; req_wdata = wd; req_rlist = rl;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; mem_ok = 1'b1;
        tick; tick;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", mem_read, mem_write); end
        total++; if (done !== 1'b0 || abort !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b%b exp=000", done, abort, wb_en); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        rstn = 1'b1;
        tick;
        total++; if (done !== 1'b0 || wb_en !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL idle_memok got=%b%b%b exp=001", done, wb_en, req_ready); end
        mem_ok = 1'b0;
    endtask

    task automatic test_load_word;
        issue(2'd0, 32'h0800_0002, 2'd2, 1'b0, 4'd5, 32'h0, 16'h0);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ldw_ready got=%b exp=0", req_ready); end
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL ldw_strobe got=%b%b exp=10", mem_read, mem_write); end
        total++; if (mem_addr !== 32'h0800_0000) begin bad++; $display("FAIL ldw_addr got=%h exp=08000000", mem_addr); end
        total++; if (mem_width !== 2'd2) begin bad++; $display("FAIL ldw_width got=%0d exp=2", mem_width); end
        mem_ok = 1'b1; mem_rdata = 32'h1122_3344;
        tick;
        mem_ok = 1'b0; mem_rdata = 32'h0;
        total++; if (done !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL ldw_done got=%b%b exp=10", done, mem_read); end
        total++; if (wb_en !== 1'b1 || wb_idx !== 4'd5) begin bad++; $display("FAIL ldw_wb got=%b/%0d exp=1/5", wb_en, wb_idx); end
        total++; if (wb_data !== 32'h3344_1122) begin bad++; $display("FAIL ldw_data got=%h exp=33441122", wb_data); end
        tick;
        total++; if (done !== 1'b0 || wb_en !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL ldw_after got=%b%b%b exp=001", done, wb_en, req_ready); end
    endtask

    task automatic test_load_ext;
        issue(2'd0, 32'h0000_0003, 2'd0, 1'b1, 4'd1, 32'h0, 16'h0);
        total++; if (mem_addr !== 32'h3 || mem_width !== 2'd0) begin bad++; $display("FAIL ldsb_bus got=%h/%0d exp=3/0", mem_addr, mem_width); end
        mem_ok = 1'b1; mem_rdata = 32'h8000_0000; tick; mem_ok = 1'b0;
        total++; if (wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldsb_data got=%h exp=ffffff80", wb_data); end
        tick;
        issue(2'd0, 32'h0000_0002, 2'd1, 1'b0, 4'd2, 32'h0, 16'h0);
        total++; if (mem_addr !== 32'h2 || mem_width !== 2'd1) begin bad++; $display("FAIL lduh_bus got=%h/%0d exp=2/1", mem_addr, mem_width); end
        mem_ok = 1'b1; mem_rdata = 32'h8000_0000; tick; mem_ok = 1'b0;
        total++; if (wb_data !== 32'h0000_8000 || wb_idx !== 4'd2) begin bad++; $display("FAIL lduh_data got=%h/%0d exp=00008000/2", wb_data, wb_idx); end
        tick;
        issue(2'd0, 32'h0000_0001, 2'd1, 1'b1, 4'd3, 32'h0, 16'h0);
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL ldsh_addr got=%h exp=0", mem_addr); end
        mem_ok = 1'b1; mem_rdata = 32'h0000_8001; tick; mem_ok = 1'b0;
        total++; if (wb_data !== 32'hFFFF_8001) begin bad++; $display("FAIL ldsh_data got=%h exp=ffff8001", wb_data); end
        tick;
        issue(2'd0, 32'h0000_0005, 2'd0, 1'b0, 4'd4, 32'h0, 16'h0);
        total++; if (mem_addr !== 32'h5) begin bad++; $display("FAIL ldub_addr got=%h exp=5", mem_addr); end
        mem_ok = 1'b1; mem_rdata = 32'h0000_9100; tick; mem_ok = 1'b0;
        total++; if (wb_data !== 32'h0000_0091) begin bad++; $display("FAIL ldub_data got=%h exp=00000091", wb_data); end
        tick;
    endtask

    task automatic test_store;
        issue(2'd1, 32'h0000_0101, 2'd0, 1'b0, 4'd0, 32'h0000_00A5, 16'h0);
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL stb_strobe got=%b%b exp=10", mem_write, mem_read); end
        total++; if (mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL stb_wdata got=%h exp=a5a5a5a5", mem_wdata); end
        total++; if (mem_addr !== 32'h101 || mem_width !== 2'd0) begin bad++; $display("FAIL stb_bus got=%h/%0d exp=101/0", mem_addr, mem_width); end
        mem_ok = 1'b1; tick; mem_ok = 1'b0;
        total++; if (done !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL stb_done got=%b/%b exp=1/0", done, wb_en); end
        tick;
        issue(2'd1, 32'h0000_0103, 2'd1, 1'b0, 4'd0, 32'h1234_BEEF, 16'h0);
        total++; if (mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h102) begin bad++; $display("FAIL sth_bus got=%h/%h exp=beefbeef/102", mem_wdata, mem_addr); end
        mem_ok = 1'b1; tick; mem_ok = 1'b0; tick;
        issue(2'd1, 32'h0000_0106, 2'd2, 1'b0, 4'd0, 32'h0102_0304, 16'h0);
        total++; if (mem_wdata !== 32'h0102_0304 || mem_addr !== 32'h104) begin bad++; $display("FAIL stw_bus got=%h/%h exp=01020304/104", mem_wdata, mem_addr); end
        mem_ok = 1'b1; tick; mem_ok = 1'b0; tick;
    endtask

    task automatic test_stm;
        logic [3:0] exp_idx [3];
        exp_idx[0] = 4'd0; exp_idx[1] = 4'd2; exp_idx[2] = 4'd15;
        issue(2'd3, 32'h0000_0100, 2'd0, 1'b0, 4'd0, 32'h0, 16'h8005);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                mem_ok = (c == 2);
                total++; if (mem_write !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * k)) begin bad++; $display("FAIL stm_addr beat=%0d got=%b/%h exp=1/%h", k, mem_write, mem_addr, 32'h100 + 32'(4 * k)); end
                total++; if (rf_idx !== exp_idx[k] || mem_wdata !== (32'hCAFE_0000 | {28'h0, exp_idx[k]})) begin bad++; $display("FAIL stm_data beat=%0d got=%0d/%h exp=%0d", k, rf_idx, mem_wdata, exp_idx[k]); end
                total++; if (done !== 1'b0 || mem_width !== 2'd2) begin bad++; $display("FAIL stm_busy beat=%0d got=%b/%0d exp=0/2", k, done, mem_width); end
                tick;
            end
        end
        mem_ok = 1'b0;
        total++; if (done !== 1'b1 || mem_write !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL stm_done got=%b%b%b exp=100", done, mem_write, wb_en); end
        tick;
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL stm_after got=%b%b exp=01", done, req_ready); end
    endtask

    task automatic test_ldm_empty_reset;
        issue(2'd2, 32'h0000_0300, 2'd0, 1'b0, 4'd0, 32'h0, 16'h0000);
        total++; if (done !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL ldm0_c1 got=%b%b exp=00", done, mem_read); end
        tick;
        total++; if (done !== 1'b1 || mem_read !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL ldm0_c2 got=%b%b%b exp=100", done, mem_read, wb_en); end
        tick;
        total++; if (done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL ldm0_c3 got=%b%b exp=01", done, req_ready); end
        issue(2'd2, 32'h0000_0200, 2'd0, 1'b0, 4'd0, 32'h0, 16'h0003);
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL ldm_b0 got=%b/%h exp=1/200", mem_read, mem_addr); end
        mem_ok = 1'b1; mem_rdata = 32'hDEAD_0001; tick; mem_ok = 1'b0;
        total++; if (wb_en !== 1'b1 || wb_idx !== 4'd0 || wb_data !== 32'hDEAD_0001) begin bad++; $display("FAIL ldm_wb0 got=%b/%0d/%h exp=1/0/dead0001", wb_en, wb_idx, wb_data); end
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h204 || done !== 1'b0) begin bad++; $display("FAIL ldm_b1 got=%b/%h/%b exp=1/204/0", mem_read, mem_addr, done); end
        rstn = 1'b0; mem_ok = 1'b1; mem_rdata = 32'hBEEF_0002;
        tick;
        mem_ok = 1'b0;
        total++; if (mem_read !== 1'b0 || wb_en !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL ldm_rst got=%b%b%b%b exp=0001", mem_read, wb_en, done, req_ready); end
        rstn = 1'b1;
        tick;
        total++; if (wb_en !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ldm_rst2 got=%b%b exp=00", wb_en, done); end
    endtask

    task automatic test_back_to_back;
        issue(2'd2, 32'hFFFF_FFFE, 2'd0, 1'b0, 4'd0, 32'h0, 16'h0006);
        total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a0 got=%h exp=fffffffc", mem_addr); end
        mem_ok = 1'b1; mem_rdata = 32'h0000_0011; tick;
        total++; if (mem_addr !== 32'h0 || wb_idx !== 4'd1 || wb_data !== 32'h11) begin bad++; $display("FAIL wrap_a1 got=%h/%0d/%h exp=0/1/11", mem_addr, wb_idx, wb_data); end
        mem_rdata = 32'h0000_0022; tick; mem_ok = 1'b0;
        total++; if (done !== 1'b1 || wb_en !== 1'b1 || wb_idx !== 4'd2 || wb_data !== 32'h22) begin bad++; $display("FAIL wrap_end got=%b%b/%0d/%h exp=11/2/22", done, wb_en, wb_idx, wb_data); end
        req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h40; req_width = 2'd2; req_rd = 4'd9;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", req_ready); end
        tick;
        total++; if (req_ready !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b exp=10", req_ready, mem_read); end
        tick;
        req_valid = 1'b0;
        total++; if (mem_read !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL b2b_acc got=%b/%h exp=1/40", mem_read, mem_addr); end
        mem_ok = 1'b1; mem_rdata = 32'hAABB_CCDD; tick; mem_ok = 1'b0;
        total++; if (wb_data !== 32'hAABB_CCDD || wb_idx !== 4'd9 || done !== 1'b1) begin bad++; $display("FAIL b2b_wb got=%h/%0d/%b exp=aabbccdd/9/1", wb_data, wb_idx, done); end
        tick;
    endtask

    task automatic test_wait;
        issue(2'd0, 32'h0000_0010, 2'd2, 1'b0, 4'd3, 32'h0, 16'h0);
`ifdef ARM_LSU_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            total++; if (done !== 1'b0 || abort !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL tmo_wait cyc=%0d got=%b%b%b exp=001", c, done, abort, mem_read); end
            tick;
        end
        total++; if (done !== 1'b1 || abort !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL tmo_hit got=%b%b%b exp=110", done, abort, wb_en); end
        tick;
        total++; if (mem_read !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL tmo_after got=%b%b%b%b exp=0001", mem_read, done, wb_en, req_ready); end
`else
        for (int c = 1; c < 8; c++) begin
            total++; if (done !== 1'b0 || abort !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL wait_hold cyc=%0d got=%b%b%b exp=001", c, done, abort, mem_read); end
            tick;
        end
        mem_ok = 1'b1; mem_rdata = 32'h5555_AAAA; tick; mem_ok = 1'b0;
        total++; if (done !== 1'b1 || abort !== 1'b0 || wb_data !== 32'h5555_AAAA) begin bad++; $display("FAIL wait_done got=%b%b/%h exp=10/5555aaaa", done, abort, wb_data); end
        tick;
`endif
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = 32'h0; req_width = 2'd0;
        req_signed = 1'b0; req_rd = 4'd0; req_wdata = 32'h0; req_rlist = 16'h0;
        mem_rdata = 32'h0; mem_ok = 1'b0;
        test_reset;
        test_load_word;
        test_load_ext;
        test_store;
        test_stm;
        test_ldm_empty_reset;
        test_back_to_back;
        test_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
